// File: rtl/maze_solver_ctrl_pkg.sv
// Shared types and constants for the depth-first maze solver.
// Direction codes double as stack entries and emitted path moves.
package maze_solver_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CHKSTART,
        MARK,
        NEXT,
        READ,
        EVAL,
        PUSH,
        POP,
        DONE,
        EMIT,
        FAIL
    } state_t;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;
    localparam logic [2:0] DIR_END   = 3'd4;

    // Flipping bit 1 swaps right/left and down/up.
    localparam logic [1:0] OPP_MASK = 2'b10;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        return d ^ OPP_MASK;
    endfunction

endpackage

// File: rtl/maze_dir_stack.sv
// Move-direction stack: synchronous push/pop, combinational top
// and indexed read for replaying the path bottom-first.
module maze_dir_stack #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    din,
    input  logic [AW-2:0] rd_idx,
    output logic [1:0]    rd_data,
    output logic [1:0]    top,
    output logic [AW-1:0] sp
);

    logic [1:0]    mem [DEPTH];
    logic [AW-2:0] top_idx;

    assign top_idx = sp[AW-2:0] - 1'b1;
    assign top     = mem[top_idx];
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (clr) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + AW'(1);
        end else if (pop) begin
            sp <= sp - AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp[AW-2:0]] <= din;
        end
    end

endmodule

// File: rtl/maze_solver_ctrl.sv
// Depth-first maze solver: marks visited cells in external memory,
// backtracks via a direction stack and replays the found path.
module maze_solver_ctrl
    import maze_solver_ctrl_pkg::*;
#(
    parameter int N      = 4,
    parameter int GOAL_X = (1 << N) - 1,
    parameter int GOAL_Y = (1 << N) - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         done,
    output logic         fail,
    output logic [N-1:0] mem_x,
    output logic [N-1:0] mem_y,
    output logic         mem_rd,
    output logic         mem_wr,
    output logic         mem_din,
    input  logic         mem_dout,
    output logic [1:0]   path_dir,
    output logic         path_valid,
    input  logic         path_ready
);

    localparam int DEPTH = 1 << (2 * N);
    localparam int AW    = 2 * N + 1;
    localparam int IW    = 2 * N;
    localparam logic [N-1:0] MAXC = {N{1'b1}};

    state_t        state;
    logic          phase;
    logic          emitted;
    logic [2:0]    dir;
    logic [N-1:0]  cur_x;
    logic [N-1:0]  cur_y;
    logic [AW-1:0] ri;
    logic [AW-1:0] sp;
    logic [IW-1:0] rd_idx;
    logic [1:0]    rd_data;
    logic [1:0]    top_dir;
    logic [1:0]    mv_dir;
    logic [N-1:0]  nbr_x;
    logic [N-1:0]  nbr_y;
    logic          nbr_ok;
    logic          accept;
    logic          push;
    logic          pop;
    logic          at_goal;
    logic          last;

    assign mem_din = 1'b1;
    assign accept  = start && (state == IDLE || state == DONE || state == FAIL);
    assign push    = (state == PUSH);
    assign pop     = (state == POP) && (sp != '0);
    assign at_goal = (cur_x == N'(GOAL_X)) && (cur_y == N'(GOAL_Y));
    assign last    = (ri == sp - AW'(1));
    assign rd_idx  = (state == EMIT) ? IW'(ri + AW'(1)) : '0;
    assign mv_dir  = (state == POP) ? opposite(top_dir) : dir[1:0];

    // One adder serves both the forward probe and the backtrack step.
    always_comb begin
        nbr_x  = cur_x;
        nbr_y  = cur_y;
        nbr_ok = 1'b0;
        case (mv_dir)
            DIR_RIGHT: begin
                nbr_y  = cur_y + N'(1);
                nbr_ok = (cur_y != MAXC);
            end
            DIR_DOWN: begin
                nbr_x  = cur_x + N'(1);
                nbr_ok = (cur_x != MAXC);
            end
            DIR_LEFT: begin
                nbr_y  = cur_y - N'(1);
                nbr_ok = (cur_y != '0);
            end
            default: begin
                nbr_x  = cur_x - N'(1);
                nbr_ok = (cur_x != '0);
            end
        endcase
    end

    maze_dir_stack #(.DEPTH(DEPTH)) u_stack (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .push    (push),
        .pop     (pop),
        .din     (dir[1:0]),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .top     (top_dir),
        .sp      (sp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 1'b0;
            emitted    <= 1'b0;
            dir        <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            ri         <= '0;
            done       <= 1'b0;
            fail       <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_x      <= '0;
            mem_y      <= '0;
            path_valid <= 1'b0;
            path_dir   <= '0;
        end else if (accept) begin
            state      <= CHKSTART;
            phase      <= 1'b0;
            emitted    <= 1'b0;
            dir        <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            ri         <= '0;
            done       <= 1'b0;
            fail       <= 1'b0;
            mem_rd     <= 1'b1;
            mem_wr     <= 1'b0;
            mem_x      <= '0;
            mem_y      <= '0;
            path_valid <= 1'b0;
        end else begin
            case (state)
                CHKSTART: begin
                    phase <= ~phase;
                    if (phase) begin
                        mem_rd <= 1'b0;
                        if (mem_dout) begin
                            state <= FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state  <= MARK;
                            mem_wr <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    mem_wr <= 1'b0;
                    if (at_goal) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (dir == DIR_END) begin
                        state <= POP;
                    end else if (!nbr_ok) begin
                        dir <= dir + 3'd1;
                    end else begin
                        state  <= READ;
                        mem_rd <= 1'b1;
                        mem_x  <= nbr_x;
                        mem_y  <= nbr_y;
                    end
                end
                READ: state <= EVAL;
                EVAL: begin
                    mem_rd <= 1'b0;
                    if (mem_dout) begin
                        dir   <= dir + 3'd1;
                        state <= NEXT;
                    end else begin
                        state <= PUSH;
                    end
                end
                PUSH: begin
                    cur_x  <= mem_x;
                    cur_y  <= mem_y;
                    dir    <= '0;
                    mem_wr <= 1'b1;
                    state  <= MARK;
                end
                POP: begin
                    if (sp == '0) begin
                        state <= FAIL;
                        fail  <= 1'b1;
                    end else begin
                        cur_x <= nbr_x;
                        cur_y <= nbr_y;
                        dir   <= {1'b0, top_dir} + 3'd1;
                        state <= NEXT;
                    end
                end
                DONE: begin
                    if (sp != '0 && !emitted) begin
                        state      <= EMIT;
                        ri         <= '0;
                        path_valid <= 1'b1;
                        path_dir   <= rd_data;
                    end
                end
                EMIT: begin
                    if (path_ready) begin
                        if (last) begin
                            state      <= DONE;
                            path_valid <= 1'b0;
                            emitted    <= 1'b1;
                        end else begin
                            ri       <= ri + AW'(1);
                            path_dir <= rd_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
